// File: rtl/reg_wb_queue.sv
// Write-back queue: accepts up to two results per cycle (load older than ALU), drains one per cycle
// into reg_file's single write port. Optional forwarding lookup is enabled by defining REG_WB_FWD_EN.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rstd,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_addr,
  input  logic [DW-1:0]            ld_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  output logic                     wren,
  output logic [AW-1:0]            wa,
  output logic [DW-1:0]            wr,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data1,
  output logic [DW-1:0]            fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ALU_LIM  = CW'(DEPTH - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    alu_slot;
  logic [CW-1:0]    push_cnt;
  logic [CW-1:0]    count_next;
  logic             ld_push;
  logic             alu_push;
  logic             pop;
  entry_t           head;

  // Ready looks only at the registered count, so a drain never lends space in the same cycle.
  assign ld_ready  = (count < FULL_CNT);
  assign alu_ready = (count < ALU_LIM);

  // Writes to r0 complete the handshake but are dropped here.
  assign ld_push  = ld_valid  & ld_ready  & (ld_addr  != '0);
  assign alu_push = alu_valid & alu_ready & (alu_addr != '0);
  assign pop      = (count != '0);

  assign alu_slot   = ld_push ? (wr_ptr + PW'(1)) : wr_ptr;
  assign push_cnt   = {{(CW-1){1'b0}}, ld_push} + {{(CW-1){1'b0}}, alu_push};
  assign count_next = count + push_cnt - {{(CW-1){1'b0}}, pop};

  assign head = mem[rd_ptr];
  assign wren = ~pop;
  assign wa   = pop ? head.addr : '0;
  assign wr   = pop ? head.data : '0;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld    <= '0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push_cnt);
      if (pop)      vld[rd_ptr]   <= 1'b0;
      if (ld_push)  vld[wr_ptr]   <= 1'b1;
      if (alu_push) vld[alu_slot] <= 1'b1;
    end
  end

  // NOTE: payload storage is not reset; vld and count decide whether an entry is ever observed.
  always_ff @(posedge clk) begin
    if (ld_push)  mem[wr_ptr]   <= '{addr: ld_addr,  data: ld_data};
    if (alu_push) mem[alu_slot] <= '{addr: alu_addr, data: alu_data};
  end

`ifdef REG_WB_FWD_EN
  // Scan oldest to youngest so the last match (youngest entry) supplies the data.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    logic [PW-1:0] slot;
    slot      = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (vld[slot] && (mem[slot].addr == rd_addr1) && (rd_addr1 != '0)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = mem[slot].data;
      end
      if (vld[slot] && (mem[slot].addr == rd_addr2) && (rd_addr2 != '0)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = mem[slot].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rd_addr1, rd_addr2, vld};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: table of per-cycle vectors plus hand-written
// sequences for forwarding and mid-traffic reset.
module tb_reg_wb_queue;

`ifdef REG_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstd;
  logic        ld_valid, alu_valid;
  logic        ld_ready, alu_ready;
  logic [4:0]  ld_addr, alu_addr, wa, rd_addr1, rd_addr2;
  logic [31:0] ld_data, alu_data, wr, fwd_data1, fwd_data2;
  logic        wren, fwd_hit1, fwd_hit2;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_wb_queue dut (
    .clk(clk), .rstd(rstd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .wren(wren), .wa(wa), .wr(wr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  typedef struct {
    logic        ldv;
    logic [4:0]  lda;
    logic [31:0] ldd;
    logic        aluv;
    logic [4:0]  alua;
    logic [31:0] alud;
    logic        ewren;
    logic [4:0]  ewa;
    logic [31:0] ewr;
    logic [2:0]  ecnt;
    logic        eldr;
    logic        ealur;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ldv, input logic [4:0] lda, input logic [31:0] ldd,
                       input logic aluv, input logic [4:0] alua, input logic [31:0] alud);
    ld_valid  = ldv;  ld_addr  = lda;  ld_data  = ldd;
    alu_valid = aluv; alu_addr = alua; alu_data = alud;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle-by-cycle vectors; expectations are outputs seen before the edge that applies the inputs.
    vecs[0]  = '{0, 0,  0,    0, 0, 0,            1, 0,  0,            0, 1, 1};
    vecs[1]  = '{0, 0,  0,    1, 5, 32'hDEADBEEF, 1, 0,  0,            0, 1, 1};
    vecs[2]  = '{0, 0,  0,    0, 0, 0,            0, 5,  32'hDEADBEEF, 1, 1, 1};
    vecs[3]  = '{1, 3,  'h11, 1, 4, 'h22,         1, 0,  0,            0, 1, 1};
    vecs[4]  = '{0, 0,  0,    0, 0, 0,            0, 3,  'h11,         2, 1, 1};
    vecs[5]  = '{0, 0,  0,    0, 0, 0,            0, 4,  'h22,         1, 1, 1};
    vecs[6]  = '{0, 0,  0,    1, 0, 'h55,         1, 0,  0,            0, 1, 1};
    vecs[7]  = '{0, 0,  0,    0, 0, 0,            1, 0,  0,            0, 1, 1};
    vecs[8]  = '{1, 1,  'hA1, 1, 2, 'hA2,         1, 0,  0,            0, 1, 1};
    vecs[9]  = '{1, 6,  'hB6, 1, 7, 'hB7,         0, 1,  'hA1,         2, 1, 1};
    vecs[10] = '{1, 8,  'hC8, 1, 9, 'hC9,         0, 2,  'hA2,         3, 1, 0};
    vecs[11] = '{1, 10, 'hDA, 1, 9, 'hC9,         0, 6,  'hB6,         3, 1, 0};
    vecs[12] = '{0, 0,  0,    1, 9, 'hC9,         0, 7,  'hB7,         3, 1, 0};
    vecs[13] = '{0, 0,  0,    1, 9, 'hC9,         0, 8,  'hC8,         2, 1, 1};
    vecs[14] = '{0, 0,  0,    0, 0, 0,            0, 10, 'hDA,         2, 1, 1};
    vecs[15] = '{0, 0,  0,    0, 0, 0,            0, 9,  'hC9,         1, 1, 1};
    vecs[16] = '{0, 0,  0,    0, 0, 0,            1, 0,  0,            0, 1, 1};

    rstd = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rd_addr1 = '0;
    rd_addr2 = '0;
    #12;
    check("rst_wren",  32'(wren),     32'd1);
    check("rst_wa",    32'(wa),       32'd0);
    check("rst_wr",    wr,            32'd0);
    check("rst_count", 32'(count),    32'd0);
    check("rst_hit1",  32'(fwd_hit1), 32'd0);
    check("rst_data1", fwd_data1,     32'd0);
    rstd = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].ldv, vecs[i].lda, vecs[i].ldd, vecs[i].aluv, vecs[i].alua, vecs[i].alud);
      #1;
      check($sformatf("v%0d_wren", i),      32'(wren),      32'(vecs[i].ewren));
      check($sformatf("v%0d_wa", i),        32'(wa),        32'(vecs[i].ewa));
      check($sformatf("v%0d_wr", i),        wr,             vecs[i].ewr);
      check($sformatf("v%0d_count", i),     32'(count),     32'(vecs[i].ecnt));
      check($sformatf("v%0d_ld_ready", i),  32'(ld_ready),  32'(vecs[i].eldr));
      check($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ealur));
      step();
    end

    // Forwarding: r7=1 (load, older) and r7=2 (ALU, younger) enter together.
    drive(1, 7, 32'h1, 1, 7, 32'h2);
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd0;
    #1;
    check("fwd_same_cycle_excluded", 32'(fwd_hit1), 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("fwd_count2",  32'(count),     32'd2);
    check("fwd_wa",      32'(wa),        32'd7);
    check("fwd_wr",      wr,             32'h1);
    check("fwd_hit1",    32'(fwd_hit1),  32'(FWD));
    check("fwd_data1",   fwd_data1,      FWD ? 32'h2 : 32'h0);
    check("fwd_hit2_r0", 32'(fwd_hit2),  32'd0);
    check("fwd_data2",   fwd_data2,      32'd0);
    step();
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd7;
    #1;
    check("fwd_head_hit2",  32'(fwd_hit2), 32'(FWD));
    check("fwd_head_data2", fwd_data2,     FWD ? 32'h2 : 32'h0);
    check("fwd_miss_hit1",  32'(fwd_hit1), 32'd0);
    step();
    check("fwd_empty_hit2", 32'(fwd_hit2), 32'd0);

    // Mid-traffic reset with three entries pending.
    rd_addr1 = 5'd2;
    rd_addr2 = 5'd0;
    drive(1, 1, 32'h101, 1, 2, 32'h102);
    step();
    drive(1, 3, 32'h103, 1, 4, 32'h104);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    rstd = 1'b0;
    #1;
    check("arst_wren",  32'(wren),     32'd1);
    check("arst_wa",    32'(wa),       32'd0);
    check("arst_wr",    wr,            32'd0);
    check("arst_count", 32'(count),    32'd0);
    check("arst_hit1",  32'(fwd_hit1), 32'd0);
    @(posedge clk);
    #3;
    rstd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst%0d_wren", i),  32'(wren),  32'd1);
      check($sformatf("post_rst%0d_count", i), 32'(count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
